// File: rtl/uart_rx.sv
// uart_rx: one-sample-per-clock UART receiver.
// Frame: start(0), DATA_BITS data bits LSB first, even parity bit, stop(1).
// Holds the last good word with valid / parity / overrun status and
// pulses frame_err when a stop bit is sampled low.
module uart_rx #(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PARITY,
      STOP,
      RECOVER
   } state_t;

   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   mism_q, mism_d;
   logic                   valid_q, valid_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   ovr_q, ovr_d;

   // State register; reset drops any partially received frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Frame sequencing: one state step per received bit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!rx_in) state_d = DATA;
         end
         DATA: begin
            if (cnt_q == LAST_BIT) state_d = PARITY;
         end
         PARITY: begin
            state_d = STOP;
         end
         STOP: begin
            state_d = rx_in ? IDLE : RECOVER;
         end
         RECOVER: begin
            if (rx_in) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath and status next values; an ack is applied first so a word
   // landing on the same edge still wins and stays valid.
   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      mism_d  = mism_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      ovr_d   = ovr_q;
      ferr_d  = 1'b0;
      busy    = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (!rx_in) cnt_d = 4'd0;
         end
         DATA: begin
            shift_d = {rx_in, shift_q[DATA_BITS-1:1]};
            cnt_d   = cnt_q + 4'd1;
         end
         PARITY: begin
            mism_d = rx_in ^ (^shift_q);
         end
         default: begin
         end
      endcase

      if (valid_q && rx_ack) begin
         valid_d = 1'b0;
         perr_d  = 1'b0;
         ovr_d   = 1'b0;
      end

      if (state_q == STOP) begin
         if (rx_in) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            perr_d  = mism_q;
            if (valid_q && !rx_ack) ovr_d = 1'b1;
         end else begin
            ferr_d = 1'b1;
         end
      end
   end

   // Datapath and status registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= 4'd0;
         shift_q <= '0;
         data_q  <= '0;
         mism_q  <= 1'b0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         mism_q  <= mism_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx_data    = data_q;
   assign rx_valid   = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scenario tasks plus randomized frames checked against a
// frame-level model of the receiver's visible status.
module tb_uart_rx;

   logic       clk;
   logic       rst;
   logic       rx_in;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int compared;
   int mismatched;

   logic [7:0] expData;
   logic       expValid;
   logic       expPerr;
   logic       expOvr;

   uart_rx #(.DATA_BITS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_in),
      .rx_ack     (rx_ack),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic modelReset();
      expData  = 8'h00;
      expValid = 1'b0;
      expPerr  = 1'b0;
      expOvr   = 1'b0;
   endtask

   // Idle line for n cycles, optionally holding ack; model applies the ack.
   task automatic idleCycles(input int n, input logic ack);
      for (int i = 0; i < n; i++) begin
         rx_in  = 1'b1;
         rx_ack = ack;
         tick();
         if (expValid && ack) begin
            expValid = 1'b0;
            expPerr  = 1'b0;
            expOvr   = 1'b0;
         end
      end
      rx_ack = 1'b0;
   endtask

   // Sends one full frame and checks latency, frame_err, busy and status.
   task automatic sendFrame(input logic [7:0] d, input logic par,
                            input logic stp, input logic ackOnStop);
      logic prevValid;
      prevValid = expValid;
      rx_in = 1'b0;
      tick();
      compared++;
      if (busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL busy_after_start: actual=%b required=1", busy);
      end
      for (int i = 0; i < 8; i++) begin
         rx_in = d[i];
         tick();
      end
      rx_in = par;
      tick();
      compared++;
      if (rx_valid !== prevValid) begin
         mismatched++;
         $display("[TB] FAIL valid_before_stop: actual=%b required=%b", rx_valid, prevValid);
      end
      rx_in  = stp;
      rx_ack = ackOnStop;
      tick();
      rx_ack = 1'b0;
      rx_in  = 1'b1;
      if (stp) begin
         if (expValid) expOvr = !ackOnStop;
         expData  = d;
         expValid = 1'b1;
         expPerr  = par ^ (^d);
      end else if (expValid && ackOnStop) begin
         expValid = 1'b0;
         expPerr  = 1'b0;
         expOvr   = 1'b0;
      end
      compared++;
      if (frame_err !== !stp) begin
         mismatched++;
         $display("[TB] FAIL frame_err_at_stop: actual=%b required=%b", frame_err, !stp);
      end
      compared++;
      if (busy !== !stp) begin
         mismatched++;
         $display("[TB] FAIL busy_after_stop: actual=%b required=%b", busy, !stp);
      end
      compared++;
      if (rx_data !== expData) begin
         mismatched++;
         $display("[TB] FAIL rx_data: actual=%h required=%h", rx_data, expData);
      end
      compared++;
      if (rx_valid !== expValid) begin
         mismatched++;
         $display("[TB] FAIL rx_valid: actual=%b required=%b", rx_valid, expValid);
      end
      compared++;
      if (parity_err !== expPerr) begin
         mismatched++;
         $display("[TB] FAIL parity_err: actual=%b required=%b", parity_err, expPerr);
      end
      compared++;
      if (overrun !== expOvr) begin
         mismatched++;
         $display("[TB] FAIL overrun: actual=%b required=%b", overrun, expOvr);
      end
   endtask

   task automatic test_reset();
      rst    = 1'b0;
      rx_in  = 1'b1;
      rx_ack = 1'b0;
      modelReset();
      tick();
      tick();
      compared++;
      if ({rx_data, rx_valid, parity_err, frame_err, overrun, busy} !== 13'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: actual=%h/%b%b%b%b%b required=all zero",
                  rx_data, rx_valid, parity_err, frame_err, overrun, busy);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_basic_a5();
      sendFrame(8'hA5, 1'b0, 1'b1, 1'b0);
      idleCycles(1, 1'b1);
   endtask

   task automatic test_parity_err();
      sendFrame(8'h01, 1'b0, 1'b1, 1'b0);
      compared++;
      if (parity_err !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL parity_err_set: actual=%b required=1", parity_err);
      end
      idleCycles(1, 1'b1);
      compared++;
      if ({rx_valid, parity_err} !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL ack_clears_parity: actual=%b%b required=00", rx_valid, parity_err);
      end
   endtask

   task automatic test_frame_err();
      sendFrame(8'h3C, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         rx_in = 1'b0;
         tick();
         compared++;
         if ({busy, rx_valid, frame_err} !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL recover_hold: actual=busy%b valid%b ferr%b required=busy1 valid0 ferr0",
                     busy, rx_valid, frame_err);
         end
      end
      rx_in = 1'b1;
      tick();
      tick();
      compared++;
      if ({busy, rx_valid} !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL recover_exit: actual=busy%b valid%b required=busy0 valid0", busy, rx_valid);
      end
   endtask

   task automatic test_back_to_back();
      sendFrame(8'h11, 1'b0, 1'b1, 1'b0);
      sendFrame(8'h22, 1'b0, 1'b1, 1'b0);
      idleCycles(1, 1'b1);
      compared++;
      if ({rx_valid, overrun} !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL ack_clears_overrun: actual=%b%b required=00", rx_valid, overrun);
      end
   endtask

   task automatic test_ack_on_stop();
      idleCycles(2, 1'b1);
      compared++;
      if ({rx_valid, overrun} !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL ack_without_valid: actual=%b%b required=00", rx_valid, overrun);
      end
      sendFrame(8'h33, 1'b0, 1'b1, 1'b0);
      sendFrame(8'h44, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_reset_midframe();
      rx_in = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         rx_in = 1'b1;
         tick();
      end
      #2;
      rst = 1'b0;
      #1;
      modelReset();
      compared++;
      if ({rx_data, rx_valid, parity_err, frame_err, overrun, busy} !== 13'd0) begin
         mismatched++;
         $display("[TB] FAIL async_reset: actual=%h/%b%b%b%b%b required=all zero",
                  rx_data, rx_valid, parity_err, frame_err, overrun, busy);
      end
      rx_in = 1'b0;
      tick();
      tick();
      rx_in = 1'b1;
      rst   = 1'b1;
      tick();
      sendFrame(8'h5A, 1'b0, 1'b1, 1'b0);
      idleCycles(1, 1'b1);
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       flip;
      logic       stp;
      logic       ack;
      int         gap;
      for (int n = 0; n < 40; n++) begin
         d    = 8'($urandom);
         flip = ($urandom_range(0, 3) == 0);
         stp  = ($urandom_range(0, 7) != 0);
         ack  = $urandom_range(0, 1) == 1;
         sendFrame(d, (^d) ^ flip, stp, ack);
         gap = stp ? $urandom_range(0, 2) : $urandom_range(1, 3);
         if (gap > 0) idleCycles(gap, $urandom_range(0, 2) == 0);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      test_reset();
      test_basic_a5();
      test_parity_err();
      test_frame_err();
      test_back_to_back();
      test_ack_on_stop();
      test_reset_midframe();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
